// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between writeback
// requesters; registers the winner onto rf_we/rf_rd/rf_data and counts contention.
module regfile_wb_arbiter #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*5-1:0] req_rd,
  input  logic [N_REQ*32-1:0] req_data,
  input  logic               hold,
  output logic               rf_we,
  output logic [4:0]         rf_rd,
  output logic [31:0]        rf_data,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   conflict_cnt
);

  localparam int unsigned PTR_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0] r_ptr;
  logic             r_we;
  logic [4:0]       r_rd;
  logic [31:0]      r_data;
  logic [CNT_W-1:0] r_cnt;

  logic [N_REQ-1:0] w_elig;
  logic [N_REQ-1:0] w_ready;
  logic             w_found;
  logic             w_grant;
  logic             w_multi;
  logic [PTR_W-1:0] w_win;
  logic [PTR_W-1:0] w_ptr_next;
  logic [4:0]       w_win_rd;
  logic [31:0]      w_win_data;
  int unsigned      w_idx;

  // Eligibility excludes x0 targets; those are acked without using the port.
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_elig[i] = req_valid[i] && (req_rd[i*5 +: 5] != 5'd0);
    end
  end

  // Scan from r_ptr upward (mod N_REQ); the first eligible index wins.
  always_comb begin
    w_found    = 1'b0;
    w_win      = '0;
    w_win_rd   = '0;
    w_win_data = '0;
    w_idx      = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_idx = (32'(r_ptr) + k) % N_REQ;
      if (!w_found && w_elig[w_idx]) begin
        w_found    = 1'b1;
        w_win      = PTR_W'(w_idx);
        w_win_rd   = req_rd[w_idx*5 +: 5];
        w_win_data = req_data[w_idx*32 +: 32];
      end
    end
  end

  assign w_grant = w_found && !hold;
  assign w_multi = |(w_elig & (w_elig - 1'b1));
  assign w_ptr_next = (w_win == PTR_W'(N_REQ - 1)) ? '0 : w_win + 1'b1;

  always_comb begin
    w_ready = '0;
    if (rstN && !hold) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && (req_rd[i*5 +: 5] == 5'd0)) begin
          w_ready[i] = 1'b1;
        end
      end
      if (w_found) begin
        w_ready[w_win] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_ptr  <= '0;
      r_we   <= 1'b0;
      r_rd   <= '0;
      r_data <= '0;
    end else begin
      r_we <= w_grant;
      if (w_grant) begin
        r_ptr  <= w_ptr_next;
        r_rd   <= w_win_rd;
        r_data <= w_win_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (!hold && w_multi && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign req_ready    = w_ready;
  assign rf_we        = r_we;
  assign rf_rd        = r_rd;
  assign rf_data      = r_data;
  assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter: reset, round-robin,
// x0 absorption, hold, counter saturation/clear and mid-stream reset.
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rstN;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic        hold;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic        cnt_clr;
  logic [15:0] conflict_cnt;

  logic [2:0]  req_ready4;
  logic        rf_we4;
  logic [4:0]  rf_rd4;
  logic [31:0] rf_data4;
  logic [3:0]  conflict_cnt4;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wb_arbiter #(.N_REQ(3), .CNT_W(16)) dut (
    .clk(clk), .rstN(rstN), .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_data(req_data), .hold(hold), .rf_we(rf_we),
    .rf_rd(rf_rd), .rf_data(rf_data), .cnt_clr(cnt_clr), .conflict_cnt(conflict_cnt)
  );

  regfile_wb_arbiter #(.N_REQ(3), .CNT_W(4)) dut4 (
    .clk(clk), .rstN(rstN), .req_valid(req_valid), .req_ready(req_ready4),
    .req_rd(req_rd), .req_data(req_data), .hold(hold), .rf_we(rf_we4),
    .rf_rd(rf_rd4), .rf_data(rf_data4), .cnt_clr(cnt_clr), .conflict_cnt(conflict_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic v, input logic [4:0] rd, input logic [31:0] d);
    req_valid[i]       = v;
    req_rd[i*5 +: 5]   = rd;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic do_reset();
    rstN = 1'b0; hold = 1'b0; cnt_clr = 1'b0;
    req_valid = '0; req_rd = '0; req_data = '0;
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
  endtask

  task automatic test_reset();
    rstN = 1'b0; hold = 1'b0; cnt_clr = 1'b0;
    set_req(0, 1'b1, 5'd1, 32'h1111_1111);
    set_req(1, 1'b1, 5'd2, 32'h2222_2222);
    set_req(2, 1'b1, 5'd3, 32'h3333_3333);
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b exp 0", rf_we); end
    n_checks++; if (rf_rd !== 5'd0) begin n_fail++; $display("FAIL reset_rd got %0d exp 0", rf_rd); end
    n_checks++; if (rf_data !== 32'd0) begin n_fail++; $display("FAIL reset_data got %h exp 0", rf_data); end
    n_checks++; if (conflict_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", conflict_cnt); end
    n_checks++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready got %b exp 000", req_ready); end
    set_req(0, 1'b0, 5'd0, 32'd0);
    set_req(1, 1'b1, 5'd5, 32'hDEAD_BEEF);
    set_req(2, 1'b0, 5'd0, 32'd0);
    rstN = 1'b1;
    #1;
    n_checks++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL reset_release_ready got %b exp 010", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    n_checks++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL reset_release_we got %b exp 1", rf_we); end
    n_checks++; if (rf_rd !== 5'd5) begin n_fail++; $display("FAIL reset_release_rd got %0d exp 5", rf_rd); end
    n_checks++; if (rf_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL reset_release_data got %h exp deadbeef", rf_data); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_ready;
    logic [4:0] exp_rd;
    logic [31:0] exp_data;
    do_reset();
    set_req(0, 1'b1, 5'd1, 32'hA000_0000);
    set_req(1, 1'b1, 5'd2, 32'hA000_0001);
    set_req(2, 1'b1, 5'd3, 32'hA000_0002);
    for (int c = 0; c < 6; c++) begin
      exp_ready = 3'b001 << (c % 3);
      exp_rd    = 5'(c % 3 + 1);
      exp_data  = 32'hA000_0000 + 32'(c % 3);
      #1;
      n_checks++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rr_ready[%0d] got %b exp %b", c, req_ready, exp_ready); end
      @(posedge clk); #1;
      n_checks++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL rr_we[%0d] got %b exp 1", c, rf_we); end
      n_checks++; if (rf_rd !== exp_rd) begin n_fail++; $display("FAIL rr_rd[%0d] got %0d exp %0d", c, rf_rd, exp_rd); end
      n_checks++; if (rf_data !== exp_data) begin n_fail++; $display("FAIL rr_data[%0d] got %h exp %h", c, rf_data, exp_data); end
    end
    n_checks++; if (conflict_cnt !== 16'd6) begin n_fail++; $display("FAIL rr_cnt got %0d exp 6", conflict_cnt); end
    req_valid = '0;
    @(posedge clk); #1;
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rr_idle_we got %b exp 0", rf_we); end
    n_checks++; if (rf_rd !== 5'd3) begin n_fail++; $display("FAIL rr_idle_rd_hold got %0d exp 3", rf_rd); end
  endtask

  task automatic test_x0();
    set_req(0, 1'b1, 5'd0, 32'h5555_5555);
    set_req(1, 1'b0, 5'd0, 32'd0);
    set_req(2, 1'b1, 5'd7, 32'h0000_0077);
    #1;
    n_checks++; if (req_ready !== 3'b101) begin n_fail++; $display("FAIL x0_ready got %b exp 101", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    n_checks++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL x0_we got %b exp 1", rf_we); end
    n_checks++; if (rf_rd !== 5'd7) begin n_fail++; $display("FAIL x0_rd got %0d exp 7", rf_rd); end
    n_checks++; if (rf_data !== 32'h77) begin n_fail++; $display("FAIL x0_data got %h exp 77", rf_data); end
    n_checks++; if (conflict_cnt !== 16'd6) begin n_fail++; $display("FAIL x0_cnt got %0d exp 6", conflict_cnt); end
    set_req(0, 1'b1, 5'd1, 32'd1);
    set_req(1, 1'b1, 5'd2, 32'd2);
    set_req(2, 1'b1, 5'd3, 32'd3);
    #1;
    n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL x0_ptr_ready got %b exp 001", req_ready); end
    req_valid = '0;
    // only x0 with hold: still not ready
    set_req(0, 1'b1, 5'd0, 32'd0);
    hold = 1'b1;
    #1;
    n_checks++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL x0_hold_ready got %b exp 000", req_ready); end
    hold = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_hold();
    set_req(0, 1'b1, 5'd4, 32'h0000_0044);
    @(posedge clk); #1;
    req_valid = '0;
    n_checks++; if (rf_rd !== 5'd4) begin n_fail++; $display("FAIL hold_pre_rd got %0d exp 4", rf_rd); end
    set_req(0, 1'b1, 5'd1, 32'hB000_0000);
    set_req(1, 1'b1, 5'd2, 32'hB000_0001);
    set_req(2, 1'b1, 5'd3, 32'hB000_0002);
    hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL hold_ready[%0d] got %b exp 000", c, req_ready); end
      @(posedge clk); #1;
      n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL hold_we[%0d] got %b exp 0", c, rf_we); end
      n_checks++; if (conflict_cnt !== 16'd6) begin n_fail++; $display("FAIL hold_cnt[%0d] got %0d exp 6", c, conflict_cnt); end
    end
    hold = 1'b0;
    #1;
    n_checks++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL hold_resume_ready got %b exp 010", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    n_checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd2) begin n_fail++; $display("FAIL hold_resume_write got we=%b rd=%0d exp we=1 rd=2", rf_we, rf_rd); end
    n_checks++; if (conflict_cnt !== 16'd7) begin n_fail++; $display("FAIL hold_resume_cnt got %0d exp 7", conflict_cnt); end
  endtask

  task automatic test_counter();
    req_valid = '0;
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    n_checks++; if (conflict_cnt4 !== 4'd0 || conflict_cnt !== 16'd0) begin n_fail++; $display("FAIL cnt_clear_idle got %0d/%0d exp 0/0", conflict_cnt4, conflict_cnt); end
    set_req(0, 1'b1, 5'd1, 32'hC000_0000);
    set_req(1, 1'b1, 5'd2, 32'hC000_0001);
    set_req(2, 1'b0, 5'd0, 32'd0);
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 10 || c == 15) begin
        n_checks++; if (conflict_cnt4 !== 4'(c)) begin n_fail++; $display("FAIL cnt4_step[%0d] got %0d exp %0d", c, conflict_cnt4, c); end
      end
    end
    n_checks++; if (conflict_cnt4 !== 4'd15) begin n_fail++; $display("FAIL cnt4_saturate got %0d exp 15", conflict_cnt4); end
    n_checks++; if (conflict_cnt !== 16'd20) begin n_fail++; $display("FAIL cnt16_count got %0d exp 20", conflict_cnt); end
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    req_valid = '0;
    n_checks++; if (conflict_cnt4 !== 4'd0) begin n_fail++; $display("FAIL cnt4_clr_priority got %0d exp 0", conflict_cnt4); end
    n_checks++; if (conflict_cnt !== 16'd0) begin n_fail++; $display("FAIL cnt16_clr_priority got %0d exp 0", conflict_cnt); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    set_req(0, 1'b1, 5'd9, 32'h0000_0099);
    set_req(1, 1'b1, 5'd10, 32'h0000_1010);
    #1;
    n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL mid_pre_ready got %b exp 001", req_ready); end
    rstN = 1'b0;
    #1;
    n_checks++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL mid_rst_ready got %b exp 000", req_ready); end
    @(posedge clk); #1;
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL mid_rst_we got %b exp 0", rf_we); end
    rstN = 1'b1;
    #1;
    n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL mid_release_ready got %b exp 001", req_ready); end
    @(posedge clk); #1;
    n_checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd9) begin n_fail++; $display("FAIL mid_req0_write got we=%b rd=%0d exp we=1 rd=9", rf_we, rf_rd); end
    req_valid[0] = 1'b0;
    #1;
    n_checks++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL mid_req1_ready got %b exp 010", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    n_checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd10 || rf_data !== 32'h1010) begin n_fail++; $display("FAIL mid_req1_write got we=%b rd=%0d data=%h exp we=1 rd=10 data=1010", rf_we, rf_rd, rf_data); end
    @(posedge clk); #1;
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL mid_idle_we got %b exp 0", rf_we); end
  endtask

  initial begin
    rstN = 1'b0; hold = 1'b0; cnt_clr = 1'b0;
    req_valid = '0; req_rd = '0; req_data = '0;
    test_reset();
    test_round_robin();
    test_x0();
    test_hold();
    test_counter();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
